rsa_engine_arbiter: RTL
=======================

Name: rsa_engine_arbiter

Overview:
- Shares one RSA exponent/modulo engine (start/done handshake, 64-bit message and keys in, 64-bit result out) between NUM_REQ requesters.
- Round-robin arbitration; captures the winner's operands, issues a one-cycle start, waits for done, returns the result to the winner only.
- Sits between client blocks (key exchange, bulk encrypt) and the single engine instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PTR_W, 2, round-robin pointer/ID width; must equal clog2(NUM_REQ).
- TIMEOUT_CYC, 4096, engine watchdog limit in cycles (used only with RSA_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester job request.
- req_msg  in  64*NUM_REQ  message; slice i = bits [64i+63:64i].
- req_pri_key  in  64*NUM_REQ  exponent key, same slicing.
- req_pub_key  in  64*NUM_REQ  modulus key, same slicing.
- req_ready  out  NUM_REQ  one-hot; job accepted on a cycle with req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_REQ  one-hot; result pending for requester i.
- rsp_data  out  64  result value.
- rsp_err  out  1  result invalid (timeout); qualified by rsp_valid.
- rsp_ready  in  NUM_REQ  requester i accepts its result.
- eng_start  out  1  one-cycle start pulse to engine.
- eng_msg, eng_pri_key, eng_pub_key  out  64 each  registered operands, stable from start until done.
- eng_done  in  1  engine result valid (single-cycle pulse).
- eng_val  in  64  engine result.
- eng_rst  out  1  engine reset request.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, eng_start=0, eng_rst=0, operands=0, busy=0.
- IDLE:
  - Grant the lowest index at or after rr_ptr (wrapping) with req_valid set.
  - req_ready is combinational from the grant; at most one bit high, and only in IDLE.
  - On handshake: latch that slice's operands into eng_*, record grant ID, set rr_ptr = ID+1 mod NUM_REQ, go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE: eng_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - On eng_done: latch eng_val into rsp_data, rsp_err=0, go to RESP.
  - eng_done in the same cycle as eng_start is ignored; done is sampled only in WAIT.
- RESP:
  - rsp_valid[ID]=1; rsp_data and rsp_err hold.
  - On rsp_ready[ID]: clear rsp_valid and go to IDLE. Next grant is possible on the following cycle.
  - rsp_ready on other bits is ignored.
- Latency: request accept to eng_start = 1 cycle; eng_done to rsp_valid = 1 cycle.
- Requester changing operands after acceptance has no effect.
- Back-to-back: a requester holding req_valid is re-granted only after every other valid requester has been served once.
- rst mid-job: engine transaction abandoned, pending result discarded, all outputs return to reset values next cycle.
- eng_rst is 0 outside the timeout path.

Optional Feature:
- Macro: RSA_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT.
  - If it reaches TIMEOUT_CYC without eng_done: eng_rst=1 for one cycle (ABORT state), then RESP with rsp_err=1 and rsp_data=0.
  - eng_done arriving in the ABORT cycle is ignored.
- Undefined: no counter, no ABORT state; eng_rst tied 0; rsp_err tied 0; WAIT waits indefinitely.

Test Plan:
- Single job, req 0: msg=5, pri=3, pub=7, engine model latency 20 -> eng_start once, 1 cycle after accept; rsp_valid=4'b0001, rsp_data=6, rsp_err=0; clears the cycle after rsp_ready[0].
- All four request together, rr_ptr=0, each holds valid -> grant order 0,1,2,3,0; exactly one req_ready bit per grant; each rsp_data goes to the correct ID.
- Requester 2 drops req_valid while 1 is being served, then re-asserts -> pointer skips to 3 and wraps to 0; no grant is ever given without req_valid.
- Hold rsp_ready=0 for 50 cycles in RESP -> rsp_valid and rsp_data stable; no new grant; eng_start stays 0.
- Assert rst during WAIT at engine cycle 10 -> next cycle all outputs at reset values; a late eng_done produces no rsp_valid.
- With RSA_ARB_TIMEOUT_EN and TIMEOUT_CYC=64, engine never completes -> eng_rst pulses at WAIT cycle 64; rsp_valid for the ID with rsp_err=1, rsp_data=0; the next request proceeds normally.

Source files
------------

// File: rtl/rsa_engine_arbiter_if.sv
// rsa_engine_arbiter_if: requester-side bus of the RSA engine arbiter.
// Carries the per-requester job request and result handshakes.
//   master : the requester cluster (drives jobs, accepts results)
//   slave  : the arbiter (accepts jobs, returns results)

interface rsa_engine_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [64*NUM_REQ-1:0] req_msg;
    logic [64*NUM_REQ-1:0] req_pri_key;
    logic [64*NUM_REQ-1:0] req_pub_key;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [63:0]           rsp_data;
    logic                  rsp_err;
    logic [NUM_REQ-1:0]    rsp_ready;

    modport master (
        output req_valid,
        output req_msg,
        output req_pri_key,
        output req_pub_key,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_msg,
        input  req_pri_key,
        input  req_pub_key,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );
endinterface

// File: rtl/rsa_engine_arbiter.sv
// rsa_engine_arbiter: shares one RSA exponent/modulo engine between NUM_REQ
// requesters with round-robin arbitration. The winner's operands are latched,
// the engine gets a one-cycle start, and the result goes back to the winner.
// Optional engine watchdog: define RSA_ARB_TIMEOUT_EN to abort a job that has
// not completed within TIMEOUT_CYC cycles (eng_rst pulse, result with rsp_err).

module rsa_engine_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int PTR_W       = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    rsa_engine_arbiter_if.slave req_bus,
    output logic                eng_start,
    output logic [63:0]         eng_msg,
    output logic [63:0]         eng_pri_key,
    output logic [63:0]         eng_pub_key,
    input  logic                eng_done,
    input  logic [63:0]         eng_val,
    output logic                eng_rst,
    output logic                busy
);

    // Elaboration-time guard against inconsistent parameter sets.
    if (NUM_REQ < 2 || NUM_REQ > 8 || PTR_W != $clog2(NUM_REQ) || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("rsa_engine_arbiter: invalid NUM_REQ/PTR_W/TIMEOUT_CYC combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
`ifdef RSA_ARB_TIMEOUT_EN
        ST_ABORT,
`endif
        ST_RESP
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_id;
    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] ready_vec;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [63:0]        rsp_data_q;
    logic [63:0]        sel_msg;
    logic [63:0]        sel_pri_key;
    logic [63:0]        sel_pub_key;

`ifdef RSA_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic              rsp_err_q;
    logic              eng_rst_q;
    logic [CNT_W-1:0]  wd_cnt;
`endif

    // Requester index reached by stepping off positions past base, modulo NUM_REQ.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return PTR_W'(sum);
    endfunction

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [PTR_W-1:0] id);
        logic [NUM_REQ-1:0] vec;
        vec     = '0;
        vec[id] = 1'b1;
        return vec;
    endfunction

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    // Scanning from the far end lets the nearest candidate win last.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_bus.req_valid[wrap_add(rr_ptr, k)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_add(rr_ptr, k);
            end
        end
    end

    // Ready is offered only while idle and never while reset is asserted.
    always_comb begin
        ready_vec = '0;
        if (state == ST_IDLE && grant_vld && !rst) begin
            ready_vec = id_onehot(grant_idx);
        end
    end

    assign sel_msg     = req_bus.req_msg[64*int'(grant_idx) +: 64];
    assign sel_pri_key = req_bus.req_pri_key[64*int'(grant_idx) +: 64];
    assign sel_pub_key = req_bus.req_pub_key[64*int'(grant_idx) +: 64];

    assign req_bus.req_ready = ready_vec;
    assign req_bus.rsp_valid = rsp_valid_q;
    assign req_bus.rsp_data  = rsp_data_q;
    assign busy              = (state != ST_IDLE);

`ifdef RSA_ARB_TIMEOUT_EN
    assign req_bus.rsp_err = rsp_err_q;
    assign eng_rst         = eng_rst_q;
`else
    assign req_bus.rsp_err = 1'b0;
    assign eng_rst         = 1'b0;
`endif

    // Job sequencer: accept, issue start, wait for the engine, hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            gnt_id      <= '0;
            eng_start   <= 1'b0;
            eng_msg     <= '0;
            eng_pri_key <= '0;
            eng_pub_key <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
`ifdef RSA_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            eng_rst_q   <= 1'b0;
            wd_cnt      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        eng_msg     <= sel_msg;
                        eng_pri_key <= sel_pri_key;
                        eng_pub_key <= sel_pub_key;
                        gnt_id      <= grant_idx;
                        rr_ptr      <= wrap_add(grant_idx, 1);
                        eng_start   <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A done coincident with start is not looked at here.
                    eng_start <= 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
                    wd_cnt    <= '0;
`endif
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        rsp_data_q  <= eng_val;
                        rsp_valid_q <= id_onehot(gnt_id);
`ifdef RSA_ARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state       <= ST_RESP;
                    end
`ifdef RSA_ARB_TIMEOUT_EN
                    else if (wd_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        eng_rst_q <= 1'b1;
                        state     <= ST_ABORT;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
`ifdef RSA_ARB_TIMEOUT_EN
                ST_ABORT: begin
                    // Engine is being reset; any done seen now is stale.
                    eng_rst_q   <= 1'b0;
                    rsp_data_q  <= '0;
                    rsp_err_q   <= 1'b1;
                    rsp_valid_q <= id_onehot(gnt_id);
                    state       <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    if (req_bus.rsp_ready[gnt_id]) begin
                        rsp_valid_q <= '0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
